// File: rtl/usr_axil_ctrl.sv
// AXI-Lite control/status block for up to 8 compute engines: start pulses,
// busy/done capture, per-engine cycle counters and a maskable interrupt.
module usr_axil_ctrl #(
  parameter int NUM_ENG = 4,
  parameter int CNT_W   = 32,
  parameter int AXIL_AW = 32,
  parameter int AXIL_DW = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AXIL_AW-1:0] s_axil_awaddr,
  input  logic               s_axil_awvalid,
  output logic               s_axil_awready,
  input  logic [AXIL_DW-1:0] s_axil_wdata,
  input  logic [3:0]         s_axil_wstrb,
  input  logic               s_axil_wvalid,
  output logic               s_axil_wready,
  output logic [1:0]         s_axil_bresp,
  output logic               s_axil_bvalid,
  input  logic               s_axil_bready,
  input  logic [AXIL_AW-1:0] s_axil_araddr,
  input  logic               s_axil_arvalid,
  output logic               s_axil_arready,
  output logic [AXIL_DW-1:0] s_axil_rdata,
  output logic [1:0]         s_axil_rresp,
  output logic               s_axil_rvalid,
  input  logic               s_axil_rready,
  output logic [NUM_ENG-1:0] start,
  input  logic [NUM_ENG-1:0] finish,
  output logic               usr_irq_req,
  input  logic               usr_irq_ack
);

  localparam logic [1:0]       RESP_OKAY   = 2'b00;
  localparam logic [1:0]       RESP_SLVERR = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  // Word offsets 0..3 are control/status, 8..8+NUM_ENG-1 are cycle counters.
  function automatic logic is_mapped(input logic [5:0] idx);
    return (idx < 6'd4) || ((idx >= 6'd8) && (idx < 6'(8 + NUM_ENG)));
  endfunction

  logic               aw_w_ready_r;
  logic               bvalid_r;
  logic [1:0]         bresp_r;
  logic               arready_r;
  logic               rvalid_r;
  logic [AXIL_DW-1:0] rdata_r;
  logic [1:0]         rresp_r;
  logic [NUM_ENG-1:0] start_r;
  logic [NUM_ENG-1:0] busy_r;
  logic [NUM_ENG-1:0] done_r;
  logic [NUM_ENG-1:0] done_q_r;
  logic [NUM_ENG-1:0] irq_en_r;
  logic               irq_pend_r;
  logic [CNT_W-1:0]   cnt_r [NUM_ENG];

  logic               wr_hs_s;
  logic               wr_en_s;
  logic               rd_hs_s;
  logic [5:0]         wr_idx_s;
  logic [5:0]         rd_idx_s;
  logic [NUM_ENG-1:0] start_set_s;
  logic [NUM_ENG-1:0] done_clr_s;
  logic [NUM_ENG-1:0] fin_s;
  logic [NUM_ENG-1:0] done_rise_s;
  logic [CNT_W-1:0]   cyc_sel_s;
  logic [AXIL_DW-1:0] rd_data_s;
  logic               unused_s;

  assign wr_hs_s     = aw_w_ready_r && s_axil_awvalid && s_axil_wvalid;
  assign wr_en_s     = wr_hs_s && s_axil_wstrb[0];
  assign rd_hs_s     = arready_r && s_axil_arvalid;
  assign wr_idx_s    = s_axil_awaddr[7:2];
  assign rd_idx_s    = s_axil_araddr[7:2];
  assign start_set_s = (wr_en_s && (wr_idx_s == 6'd0)) ? (s_axil_wdata[NUM_ENG-1:0] & ~busy_r) : '0;
  assign done_clr_s  = (wr_en_s && (wr_idx_s == 6'd2)) ? s_axil_wdata[NUM_ENG-1:0] : '0;
  assign fin_s       = finish & busy_r;
  assign done_rise_s = done_r & ~done_q_r & irq_en_r;
  assign unused_s    = ^{s_axil_awaddr, s_axil_araddr, s_axil_wdata, s_axil_wstrb};

  // Write channel: AW and W are only taken together, one transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_w_ready_r <= 1'b0;
      bvalid_r     <= 1'b0;
      bresp_r      <= RESP_OKAY;
    end else begin
      aw_w_ready_r <= s_axil_awvalid && s_axil_wvalid && !bvalid_r && !aw_w_ready_r;
      if (wr_hs_s) begin
        bvalid_r <= 1'b1;
        bresp_r  <= is_mapped(wr_idx_s) ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axil_bready) begin
        bvalid_r <= 1'b0;
      end
    end
  end

  // Select the addressed cycle counter; unmatched offsets yield zero.
  always_comb begin
    cyc_sel_s = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      cyc_sel_s = (rd_idx_s == 6'(8 + i)) ? cnt_r[i] : cyc_sel_s;
    end
  end

  // Read data mux.
  always_comb begin
    rd_data_s = '0;
    case (rd_idx_s)
      6'd0:    rd_data_s = '0;
      6'd1:    rd_data_s[NUM_ENG-1:0] = busy_r;
      6'd2:    rd_data_s[NUM_ENG-1:0] = done_r;
      6'd3:    rd_data_s[NUM_ENG-1:0] = irq_en_r;
      default: rd_data_s[CNT_W-1:0] = cyc_sel_s;
    endcase
  end

  // Read channel: data is captured at the address handshake and held until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= '0;
      rresp_r   <= RESP_OKAY;
    end else begin
      arready_r <= s_axil_arvalid && !rvalid_r && !arready_r;
      if (rd_hs_s) begin
        rvalid_r <= 1'b1;
        rdata_r  <= rd_data_s;
        rresp_r  <= is_mapped(rd_idx_s) ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axil_rready) begin
        rvalid_r <= 1'b0;
      end
    end
  end

  // Engine status: finish beats a same-cycle W1C, and starts only land on idle engines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_r  <= '0;
      busy_r   <= '0;
      done_r   <= '0;
      done_q_r <= '0;
      irq_en_r <= '0;
    end else begin
      start_r  <= start_set_s;
      busy_r   <= (busy_r & ~fin_s) | start_set_s;
      done_r   <= (done_r & ~done_clr_s) | fin_s;
      done_q_r <= done_r;
      if (wr_en_s && (wr_idx_s == 6'd3)) begin
        irq_en_r <= s_axil_wdata[NUM_ENG-1:0];
      end
    end
  end

  // Cycle counters count every busy cycle, including the finish cycle, and saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENG; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENG; i++) begin
        if (start_set_s[i]) begin
          cnt_r[i] <= '0;
        end else if (busy_r[i] && (cnt_r[i] != CNT_MAX)) begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end
      end
    end
  end

  // Interrupt pending: a fresh enabled done edge wins over a same-cycle ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_pend_r <= 1'b0;
    end else if (|done_rise_s) begin
      irq_pend_r <= 1'b1;
    end else if (usr_irq_ack) begin
      irq_pend_r <= 1'b0;
    end
  end

  assign s_axil_awready = aw_w_ready_r;
  assign s_axil_wready  = aw_w_ready_r;
  assign s_axil_bvalid  = bvalid_r;
  assign s_axil_bresp   = bresp_r;
  assign s_axil_arready = arready_r;
  assign s_axil_rvalid  = rvalid_r;
  assign s_axil_rdata   = rdata_r;
  assign s_axil_rresp   = rresp_r;
  assign start          = start_r;
  assign usr_irq_req    = irq_pend_r;

endmodule

// File: doc/usr_axil_ctrl.md
# usr_axil_ctrl

Parametrised AXI-Lite control/status block that supersedes the single-engine start/finish controller in the user-logic top. It drives up to 8 compute engines (e.g. Matrix_Multiply instances) with per-engine start pulses, and captures their finish pulses into busy/done status. It adds per-engine cycle counters and a maskable interrupt request with acknowledge handshake, replacing the tied-off `usr_irq_req`.

## Interface
- `NUM_ENG`, 4: number of engines, legal range 1..8.
- `CNT_W`, 32: cycle-counter width, must be ≤ `AXIL_DW`.
- `AXIL_AW`, 32: AXI-Lite address width.
- `AXIL_DW`, 32: AXI-Lite data width (fixed 32).

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `s_axil_awaddr`/`awvalid`/`awready`  in/in/out  AXIL_AW/1/1  write address channel.
- `s_axil_wdata`/`wstrb`/`wvalid`/`wready`  in/in/in/out  AXIL_DW/4/1/1  write data channel.
- `s_axil_bresp`/`bvalid`/`bready`  out/out/in  2/1/1  write response channel.
- `s_axil_araddr`/`arvalid`/`arready`  in/in/out  AXIL_AW/1/1  read address channel.
- `s_axil_rdata`/`rresp`/`rvalid`/`rready`  out/out/out/in  AXIL_DW/2/1/1  read data channel.
- `start`  out  NUM_ENG  one-cycle start pulse per engine.
- `finish`  in  NUM_ENG  one-cycle completion pulse per engine.
- `usr_irq_req`  out  1  interrupt request, level, held until ack.
- `usr_irq_ack`  in  1  interrupt acknowledge pulse.

## Operation
Register map (byte offsets; decode uses `addr[7:2]`, upper bits ignored):
- 0x00 START (W, reads 0): writing 1 to bit i starts engine i.
- 0x04 BUSY (R): bit i is set while engine i runs.
- 0x08 DONE (R/W1C): bit i is set on finish of engine i.
- 0x0C IRQ_EN (RW): per-engine interrupt enable.
- 0x20+4·i CYCLES[i] (R), i < NUM_ENG: cycle count of the current or last run, zero-extended.
- Any other offset: reads return 0 with SLVERR (2'b10); writes are ignored with SLVERR. Mapped offsets respond OKAY.
- Register writes take effect only when `wstrb[0]`=1. All writable bits are in byte 0; other strobes are ignored.

Engine i behaviour:
- Idle→run: START write with bit i=1 while `busy[i]`=0 produces `start[i]`=1 for exactly one cycle. `busy[i]` is set and `CYCLES[i]` is cleared to 0.
- START bit i while `busy[i]`=1 is ignored; no pulse is produced.
- While busy, `CYCLES[i]` increments every cycle and saturates at 2^CNT_W−1.
- On `finish[i]` while busy: `busy[i]` clears, `done[i]` sets, and the counter freezes.
- `finish[i]` while idle is ignored.

Interrupt:
- `irq_pend` sets when any done bit goes 0→1 with its IRQ_EN bit =1.
- `irq_pend` clears on `usr_irq_ack`. Set wins over ack in the same cycle.
- Enabling IRQ_EN for an already-set done bit does not raise an interrupt.
- `usr_irq_req` = `irq_pend` (registered).

## Timing
- Reset: all outputs are 0 (`awready`, `wready`, `bvalid`, `bresp`, `arready`, `rvalid`, `rdata`, `rresp`, `start`, `usr_irq_req`). Internal busy/done/IRQ_EN/counters are 0.
- Write handshake:
  - `awready`=`wready`=1 for one cycle when `awvalid`&&`wvalid`&&!`bvalid`. Neither channel is accepted alone.
  - `bvalid` asserts the next cycle and is held with stable `bresp` until `bready`; it drops the cycle after the handshake.
- Read handshake:
  - `arready`=1 for one cycle when `arvalid`&&!`rvalid`.
  - `rvalid` with `rdata`/`rresp` asserts the next cycle and is held stable until `rready`.
- Start latency: the `start[i]` pulse and `busy[i]`=1 appear the cycle after the write handshake cycle. `CYCLES[i]` reads 1 one cycle later.
- Finish latency: `busy[i]`=0 and `done[i]`=1 the cycle after `finish[i]`. `usr_irq_req` follows one further cycle.
- Count: for start at cycle S+1 and finish sampled at cycle F, `CYCLES[i]` = F−S.
- Simultaneous events:
  - W1C of `done[i]` in the same cycle as a `finish[i]` set: set wins.
  - START write to engine i in the cycle `finish[i]` arrives: start is ignored (busy still 1).
- Reset mid-run: all state clears immediately. Engines are expected to be reset by the same `rst`.

## Test plan
- Reset, then read 0x04/0x08/0x0C → all 0x0000_0000 OKAY. `usr_irq_req`=0, `start`=0.
- Write 0x00=0x5, finish[0] 10 cycles after start, finish[2] 20 cycles after start → start pulses on bits 0 and 2 only. BUSY reads 0x5→0x4→0x0; DONE=0x5; CYCLES[0]=10, CYCLES[2]=20.
- IRQ_EN=0x2, run engine 1 to finish → `usr_irq_req`=1 two cycles after finish. Pulse ack → req=0 next cycle. Write DONE=0x2 → DONE=0.
- Write START bit 1 while engine 1 busy → no `start[1]` pulse; CYCLES[1] not cleared.
- Read 0x40 and write 0x14 → `rresp`=`bresp`=2'b10, rdata=0, no state change. Write 0x00 with `wstrb`=4'b1110 → no start.
- Hold `bready`=0 for 5 cycles after a write → `bvalid` stays 1 and no new AW/W is accepted. Same check with `rready` on the read side.
